lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes RV32 load/store operations, drives a single
// word-wide data memory request with byte lanes, and returns left-justified load data.
module lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [11:0]     i_operation,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [3:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_misaligned,
    output logic            o_err
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_wait;
    logic [1:0]      r_offset;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_load_data;
    logic            r_misaligned;
    logic            r_err;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_legal;
    logic            w_misaligned;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_accept;
    logic            w_reject_illegal;
    logic            w_reject_misaligned;
    logic            w_ack_take;
    logic            w_timeout;
    logic            w_unused_funct7;

    assign w_opcode        = i_operation[6:0];
    assign w_funct3        = i_operation[9:7];
    assign w_is_load       = (w_opcode == OPC_LOAD);
    assign w_is_store      = (w_opcode == OPC_STORE);
    assign w_is_mem        = w_is_load || w_is_store;
    assign w_unused_funct7 = ^i_operation[11:10];

    // Legal funct3 encodings for each memory opcode
    always_comb begin
        w_legal = 1'b0;
        if (w_is_load) begin
            case (w_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end else if (w_is_store) begin
            case (w_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                default:                w_legal = 1'b0;
            endcase
        end else begin
            w_legal = 1'b0;
        end
    end

    // Access size drives alignment, lane enables and store-data replication
    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = i_wdata;
        case (w_funct3[1:0])
            2'b00: begin
                w_be    = 4'b1000 >> i_addr[1:0];
                w_wdata = {(XLEN/8){i_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = i_addr[0];
                w_be         = i_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata      = {(XLEN/16){i_wdata[15:0]}};
            end
            default: begin
                w_misaligned = (i_addr[1:0] != 2'b00);
                w_be         = 4'b1111;
                w_wdata      = i_wdata;
            end
        endcase
    end

    // Next-state decision and transition strobes
    always_comb begin
        w_next_state        = r_state;
        w_accept            = 1'b0;
        w_reject_illegal    = 1'b0;
        w_reject_misaligned = 1'b0;
        w_ack_take          = 1'b0;
        w_timeout           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_is_mem) begin
                    if (!w_legal) begin
                        w_next_state     = S_DONE;
                        w_reject_illegal = 1'b1;
                    end else if (w_misaligned) begin
                        w_next_state        = S_DONE;
                        w_reject_misaligned = 1'b1;
                    end else begin
                        w_next_state = S_REQ;
                        w_accept     = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    w_next_state = S_DONE;
                    w_ack_take   = 1'b1;
                end else if (r_wait == 8'(TIMEOUT - 1)) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request, status and load-data registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait       <= 8'd0;
            r_offset     <= 2'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= '0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait       <= 8'd0;
                r_offset     <= i_addr[1:0];
                r_mem_we     <= w_is_store;
                r_mem_addr   <= {i_addr[XLEN-1:2], 2'b00};
                r_mem_be     <= w_be;
                r_mem_wdata  <= w_wdata;
                r_misaligned <= 1'b0;
                r_err        <= 1'b0;
            end
            if (w_reject_illegal) begin
                r_misaligned <= 1'b0;
                r_err        <= 1'b1;
            end
            if (w_reject_misaligned) begin
                r_misaligned <= 1'b1;
                r_err        <= 1'b0;
            end
            if (r_state == S_REQ && !i_mem_ack && !w_timeout) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Shift the addressed datum up to the MSB end; sign/zero extension happens downstream
            if (w_ack_take && !r_mem_we) begin
                r_load_data <= i_mem_rdata << {r_offset, 3'b000};
            end
        end
    end

    assign o_mem_req    = (r_state == S_REQ);
    assign o_done       = (r_state == S_DONE);
    assign o_stall      = !i_reset && ((r_state == S_REQ) || (r_state == S_IDLE && i_start && w_is_mem));
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_be     = r_mem_be;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_load_data  = r_load_data;
    assign o_misaligned = r_misaligned;
    assign o_err        = r_err;

endmodule
